// File: rtl/ctl_pwm_fade_10b_pkg.sv
// Shared PWM types for the 10-bit PWM controllers: duty width, full-scale value and fade FSM states.
package pkg_pwm;
    localparam int PWM_W = 10;
    localparam logic [PWM_W-1:0] PWM_MAX = 10'd1023;

    typedef logic [PWM_W-1:0] pwm_val_t;

    typedef enum logic [1:0] {
        IDLE,
        RAMP,
        DONE
    } fade_state_t;
endpackage

// File: rtl/ctl_pwm_fade_10b_if.sv
// Target-request handshake between application logic (master) and the fade controller (slave).
interface ctl_pwm_fade_10b_if;
    import pkg_pwm::*;

    pwm_val_t i_target;
    logic     i_target_vld;
    logic     o_target_rdy;

    modport master (output i_target, output i_target_vld, input o_target_rdy);
    modport slave  (input i_target, input i_target_vld, output o_target_rdy);
endinterface

// File: rtl/ctl_pwm_fade_10b_period_tick.sv
// Free-running PWM period counter; o_tick marks the last clock of each 1024-clock period.
module ctl_pwm_period_tick
    import pkg_pwm::*;
(
    input  logic i_clk,
    input  logic i_rst,
    output logic o_tick
);
    pwm_val_t r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 10'd1;
        end
    end

    assign o_tick = (r_count == PWM_MAX);
endmodule

// File: rtl/ctl_pwm_fade_10b.sv
// Fades the PWM duty toward a requested target in STEP increments every STEP_DIV periods.
// Optional macro CTL_PWM_FADE_RETARGET_EN: accept new targets while a ramp is running.
module ctl_pwm_fade_10b
    import pkg_pwm::*;
#(
    parameter pwm_val_t STEP     = 10'd1,
    parameter int       STEP_DIV = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    ctl_pwm_fade_10b_if.slave        io_tgt,
    output pwm_val_t                 o_val,
    output logic                     o_busy,
    output logic                     o_done
);
    localparam pwm_val_t   STEP_EFF = (STEP == 10'd0) ? 10'd1 : STEP;
    localparam logic [7:0] DIV_LAST = 8'(STEP_DIV - 1);
`ifdef CTL_PWM_FADE_RETARGET_EN
    localparam logic RDY_IN_RAMP = 1'b1;
`else
    localparam logic RDY_IN_RAMP = 1'b0;
`endif

    fade_state_t r_state;
    pwm_val_t    r_val;
    pwm_val_t    r_target;
    logic [7:0]  r_div;
    logic        r_busy;
    logic        r_done;
    logic        r_rdy;

    logic        w_tick;
    logic        w_step;
    logic        w_accept;
    pwm_val_t    w_next;
    pwm_val_t    w_val_after;
    pwm_val_t    w_tgt_after;

    // Gaps are taken in 11 bits so a step never wraps past 0 or 1023.
    function automatic pwm_val_t f_step(input pwm_val_t val, input pwm_val_t tgt);
        logic [PWM_W:0] up_gap;
        logic [PWM_W:0] dn_gap;
        up_gap = {1'b0, tgt} - {1'b0, val};
        dn_gap = {1'b0, val} - {1'b0, tgt};
        if (tgt > val) begin
            f_step = (up_gap <= {1'b0, STEP_EFF}) ? tgt : val + STEP_EFF;
        end else if (tgt < val) begin
            f_step = (dn_gap <= {1'b0, STEP_EFF}) ? tgt : val - STEP_EFF;
        end else begin
            f_step = val;
        end
    endfunction

    ctl_pwm_period_tick u_tick (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_tick (w_tick)
    );

    assign w_accept    = io_tgt.i_target_vld && r_rdy;
    assign w_step      = (r_state == RAMP) && w_tick && (r_div == DIV_LAST);
    assign w_next      = f_step(r_val, r_target);
    // A retarget on a step edge lands after the step, so completion is judged against it.
    assign w_val_after = w_step ? w_next : r_val;
    assign w_tgt_after = w_accept ? io_tgt.i_target : r_target;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_val    <= '0;
            r_target <= '0;
            r_div    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rdy    <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_target <= io_tgt.i_target;
                        r_div    <= '0;
                        if (io_tgt.i_target == r_val) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                            r_rdy   <= 1'b0;
                        end else begin
                            r_state <= RAMP;
                            r_busy  <= 1'b1;
                            r_rdy   <= RDY_IN_RAMP;
                        end
                    end
                end
                RAMP: begin
                    if (w_tick) begin
                        r_div <= w_step ? 8'd0 : r_div + 8'd1;
                    end
                    if (w_step) begin
                        r_val <= w_next;
                    end
                    if (w_accept) begin
                        r_target <= io_tgt.i_target;
                    end
                    if (w_val_after == w_tgt_after) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_rdy   <= 1'b0;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_rdy   <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_rdy   <= 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        assert (STEP != 10'd0) else $error("STEP of zero is illegal, treated as one");
        assert (STEP_DIV >= 1 && STEP_DIV <= 255) else $error("STEP_DIV outside 1..255");
    end

    assign io_tgt.o_target_rdy = r_rdy;
    assign o_val               = r_val;
    assign o_busy              = r_busy;
    assign o_done              = r_done;
endmodule

// File: tb/tb_ctl_pwm_fade_10b.sv
// Bench for ctl_pwm_fade_10b: three parameterisations driven by scenario tasks against a ramp model.
module tb_ctl_pwm_fade_10b;
    import pkg_pwm::*;

`ifdef CTL_PWM_FADE_RETARGET_EN
    localparam logic RETGT = 1'b1;
`else
    localparam logic RETGT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int lc = 0;
    logic rst_q = 1'b1;
    int cur [3];
    int sel = 0;

    // Model of the PWM period phase: cleared by reset, one count per clock, wraps at 1024.
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        lc    <= rst ? 0 : (lc + 1) % 1024;
        rst_q <= rst;
    end

    ctl_pwm_fade_10b_if if_a ();
    ctl_pwm_fade_10b_if if_b ();
    ctl_pwm_fade_10b_if if_c ();

    logic [9:0] vals [3];
    logic       busys [3];
    logic       dones [3];
    logic       rdys [3];

    assign rdys[0] = if_a.o_target_rdy;
    assign rdys[1] = if_b.o_target_rdy;
    assign rdys[2] = if_c.o_target_rdy;

    ctl_pwm_fade_10b #(.STEP(10'd1), .STEP_DIV(1)) dut_a (
        .i_clk(clk), .i_rst(rst), .io_tgt(if_a.slave),
        .o_val(vals[0]), .o_busy(busys[0]), .o_done(dones[0]));
    ctl_pwm_fade_10b #(.STEP(10'd100), .STEP_DIV(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .io_tgt(if_b.slave),
        .o_val(vals[1]), .o_busy(busys[1]), .o_done(dones[1]));
    ctl_pwm_fade_10b #(.STEP(10'd300), .STEP_DIV(1)) dut_c (
        .i_clk(clk), .i_rst(rst), .io_tgt(if_c.slave),
        .o_val(vals[2]), .o_busy(busys[2]), .o_done(dones[2]));

    logic [9:0] m_val;
    logic       m_busy, m_done, m_rdy;
    always_comb begin
        m_val  = vals[sel];
        m_busy = busys[sel];
        m_done = dones[sel];
        m_rdy  = rdys[sel];
    end

    // Duty may only move on the first clock of a period, except when reset clears it.
    logic [9:0] pv [3];
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (vals[i] !== pv[i]) begin
                if (!rst_q) begin
                    total++;
                    if (lc != 0) begin
                        bad++;
                        $display("FAIL phase dut%0d: o_val changed to %0d at l_count=%0d, need 0", i, vals[i], lc);
                    end
                end
                pv[i] = vals[i];
            end
        end
    end

    task automatic drive(input logic v, input logic [9:0] t);
        case (sel)
            0: begin if_a.i_target_vld = v; if_a.i_target = t; end
            1: begin if_b.i_target_vld = v; if_b.i_target = t; end
            default: begin if_c.i_target_vld = v; if_c.i_target = t; end
        endcase
    endtask

    task automatic send(input logic [9:0] t, output logic rdy_at, output int acc_cyc, output int acc_lc);
        @(negedge clk);
        drive(1'b1, t);
        rdy_at = m_rdy;
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        acc_lc  = lc;
        drive(1'b0, 10'($urandom));
    endtask

    logic [9:0] q_val [$];
    int         q_cyc [$];
    int         done_n, done_cyc;
    logic       busy_at_done, busy_first, rdy_first, rdy_after, busy_seen;

    task automatic collect(input int limit);
        logic [9:0] prev;
        int stop_at;
        q_val.delete();
        q_cyc.delete();
        done_n = 0; done_cyc = -1; busy_seen = 1'b0; stop_at = -1;
        busy_at_done = 1'bx; rdy_after = 1'bx; busy_first = 1'bx; rdy_first = 1'bx;
        prev = m_val;
        for (int k = 0; k < limit; k++) begin
            @(negedge clk);
            if (k == 0) begin
                busy_first = m_busy;
                rdy_first  = m_rdy;
            end
            if (m_val !== prev) begin
                q_val.push_back(m_val);
                q_cyc.push_back(cyc);
                prev = m_val;
            end
            if (m_busy === 1'b1) busy_seen = 1'b1;
            if (k == stop_at) begin
                rdy_after = m_rdy;
                break;
            end
            if (m_done === 1'b1) begin
                done_n++;
                done_cyc = cyc;
                busy_at_done = m_busy;
                stop_at = k + 1;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_a.i_target_vld = 1'b0; if_b.i_target_vld = 1'b0; if_c.i_target_vld = 1'b0;
        if_a.i_target = '0; if_b.i_target = '0; if_c.i_target = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            total++; if (vals[i] !== 10'd0) begin bad++; $display("FAIL reset_val dut%0d: got %0d want 0", i, vals[i]); end
            total++; if (rdys[i] !== 1'b1) begin bad++; $display("FAIL reset_rdy dut%0d: got %b want 1", i, rdys[i]); end
            total++; if (busys[i] !== 1'b0) begin bad++; $display("FAIL reset_busy dut%0d: got %b want 0", i, busys[i]); end
            total++; if (dones[i] !== 1'b0) begin bad++; $display("FAIL reset_done dut%0d: got %b want 0", i, dones[i]); end
            cur[i] = 0;
        end
    endtask

    task automatic test_ramp_up();
        logic ra;
        int ac, al, first;
        sel = 0;
        send(10'd8, ra, ac, al);
        collect(8 * 1024 + 2100);
        first = ac + 1024 - al;
        total++; if (ra !== 1'b1) begin bad++; $display("FAIL up_rdy_idle: got %b want 1", ra); end
        total++; if (busy_first !== 1'b1) begin bad++; $display("FAIL up_busy: got %b want 1", busy_first); end
        total++; if (rdy_first !== RETGT) begin bad++; $display("FAIL up_rdy_ramp: got %b want %b", rdy_first, RETGT); end
        total++; if (q_val.size() != 8) begin bad++; $display("FAIL up_steps: got %0d want 8", q_val.size()); end
        for (int k = 0; k < 8 && k < q_val.size(); k++) begin
            total++; if (q_val[k] !== 10'(k + 1)) begin bad++; $display("FAIL up_val[%0d]: got %0d want %0d", k, q_val[k], k + 1); end
            total++; if (q_cyc[k] != first + k * 1024) begin bad++; $display("FAIL up_time[%0d]: got %0d want %0d", k, q_cyc[k], first + k * 1024); end
        end
        total++; if (done_n != 1) begin bad++; $display("FAIL up_done_cnt: got %0d want 1", done_n); end
        total++; if (done_cyc != first + 7 * 1024) begin bad++; $display("FAIL up_done_time: got %0d want %0d", done_cyc, first + 7 * 1024); end
        total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL up_busy_at_done: got %b want 0", busy_at_done); end
        total++; if (rdy_after !== 1'b1) begin bad++; $display("FAIL up_rdy_after: got %b want 1", rdy_after); end
        cur[0] = 8;
    endtask

    task automatic test_equal();
        logic ra;
        int ac, al;
        sel = 0;
        send(10'(cur[0]), ra, ac, al);
        collect(6);
        total++; if (q_val.size() != 0) begin bad++; $display("FAIL eq_val_moved: got %0d changes want 0", q_val.size()); end
        total++; if (done_n != 1) begin bad++; $display("FAIL eq_done_cnt: got %0d want 1", done_n); end
        total++; if (done_cyc != ac) begin bad++; $display("FAIL eq_done_time: got %0d want %0d", done_cyc, ac); end
        total++; if (busy_seen !== 1'b0) begin bad++; $display("FAIL eq_busy: got %b want 0", busy_seen); end
        total++; if (m_val !== 10'(cur[0])) begin bad++; $display("FAIL eq_val: got %0d want %0d", m_val, cur[0]); end
    endtask

    task automatic test_reset_mid();
        logic ra;
        int ac, al, k, dn, vc;
        sel = 1;
        send(10'd600, ra, ac, al);
        k = 0;
        while (m_val !== 10'd300 && k < 4 * 2048) begin
            @(negedge clk);
            k++;
        end
        total++; if (m_val !== 10'd300) begin bad++; $display("FAIL rmid_reach: got %0d want 300", m_val); end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        total++; if (m_val !== 10'd0) begin bad++; $display("FAIL rmid_val: got %0d want 0", m_val); end
        total++; if (m_rdy !== 1'b1) begin bad++; $display("FAIL rmid_rdy: got %b want 1", m_rdy); end
        total++; if (m_busy !== 1'b0) begin bad++; $display("FAIL rmid_busy: got %b want 0", m_busy); end
        dn = 0; vc = 0;
        for (int j = 0; j < 4200; j++) begin
            if (m_done === 1'b1) dn++;
            if (m_val !== 10'd0) vc++;
            @(negedge clk);
        end
        total++; if (dn != 0) begin bad++; $display("FAIL rmid_done: got %0d pulses want 0", dn); end
        total++; if (vc != 0) begin bad++; $display("FAIL rmid_hold: got %0d nonzero cycles want 0", vc); end
        cur[0] = 0; cur[1] = 0; cur[2] = 0;
    endtask

    task automatic test_retarget();
        logic ra, rp;
        int ac, al, first, k, c1;
        logic [9:0] v1, exp_t;
        sel = 1;
        send(10'd200, ra, ac, al);
        first = ac + 1024 - al + 1024;
        k = 0;
        while (m_val === 10'(cur[1]) && k < 3 * 2048) begin
            @(negedge clk);
            k++;
        end
        c1 = cyc;
        v1 = m_val;
        total++; if (v1 !== 10'd100) begin bad++; $display("FAIL rt_first_val: got %0d want 100", v1); end
        total++; if (c1 != first) begin bad++; $display("FAIL rt_first_time: got %0d want %0d", c1, first); end
        @(negedge clk);
        drive(1'b1, 10'd50);
        rp = m_rdy;
        @(posedge clk);
        #1 drive(1'b0, 10'($urandom));
        collect(2 * 2048 + 10);
        exp_t = RETGT ? 10'd50 : 10'd200;
        total++; if (rp !== RETGT) begin bad++; $display("FAIL rt_rdy: got %b want %b", rp, RETGT); end
        total++; if (q_val.size() != 1) begin bad++; $display("FAIL rt_steps: got %0d want 1", q_val.size()); end
        total++; if (q_val.size() < 1 || q_val[0] !== exp_t) begin bad++; $display("FAIL rt_final: got %0d want %0d", m_val, exp_t); end
        total++; if (q_cyc.size() < 1 || q_cyc[0] != first + 2048) begin bad++; $display("FAIL rt_time: got %0d want %0d", done_cyc, first + 2048); end
        total++; if (done_n != 1) begin bad++; $display("FAIL rt_done_cnt: got %0d want 1", done_n); end
        cur[1] = int'(exp_t);
    endtask

    task automatic test_full_swing();
        int tgts [2];
        logic ra;
        int ac, al, s, t, d, n, first, e;
        tgts[0] = 1023; tgts[1] = 0;
        sel = 1;
        for (int r = 0; r < 2; r++) begin
            s = cur[1]; t = tgts[r];
            d = (t > s) ? t - s : s - t;
            n = (d + 99) / 100;
            send(10'(t), ra, ac, al);
            collect(n * 2048 + 2100);
            first = ac + 1024 - al + 1024;
            total++; if (q_val.size() != n) begin bad++; $display("FAIL swing%0d_steps: got %0d want %0d", r, q_val.size(), n); end
            for (int k = 0; k < n && k < q_val.size(); k++) begin
                e = (k + 1 == n) ? t : ((t > s) ? s + (k + 1) * 100 : s - (k + 1) * 100);
                total++; if (q_val[k] !== 10'(e)) begin bad++; $display("FAIL swing%0d_val[%0d]: got %0d want %0d", r, k, q_val[k], e); end
                total++; if (q_cyc[k] != first + k * 2048) begin bad++; $display("FAIL swing%0d_time[%0d]: got %0d want %0d", r, k, q_cyc[k], first + k * 2048); end
            end
            total++; if (done_n != 1) begin bad++; $display("FAIL swing%0d_done_cnt: got %0d want 1", r, done_n); end
            total++; if (done_cyc != first + (n - 1) * 2048) begin bad++; $display("FAIL swing%0d_done_time: got %0d want %0d", r, done_cyc, first + (n - 1) * 2048); end
            total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL swing%0d_busy_at_done: got %b want 0", r, busy_at_done); end
            cur[1] = t;
        end
    endtask

    task automatic test_random();
        logic ra;
        int ac, al, s, t, d, n, first, e, last;
        sel = 2;
        for (int r = 0; r < 3; r++) begin
            repeat ($urandom_range(0, 40)) @(negedge clk);
            s = cur[2];
            t = int'($urandom_range(0, 1023));
            d = (t > s) ? t - s : s - t;
            n = (d + 299) / 300;
            send(10'(t), ra, ac, al);
            collect(n * 1024 + 1100);
            first = ac + 1024 - al;
            last = (n == 0) ? ac : first + (n - 1) * 1024;
            total++; if (ra !== 1'b1) begin bad++; $display("FAIL rnd%0d_rdy: got %b want 1", r, ra); end
            total++; if (q_val.size() != n) begin bad++; $display("FAIL rnd%0d_steps %0d->%0d: got %0d want %0d", r, s, t, q_val.size(), n); end
            for (int k = 0; k < n && k < q_val.size(); k++) begin
                e = (k + 1 == n) ? t : ((t > s) ? s + (k + 1) * 300 : s - (k + 1) * 300);
                total++; if (q_val[k] !== 10'(e)) begin bad++; $display("FAIL rnd%0d_val[%0d]: got %0d want %0d", r, k, q_val[k], e); end
                total++; if (q_cyc[k] != first + k * 1024) begin bad++; $display("FAIL rnd%0d_time[%0d]: got %0d want %0d", r, k, q_cyc[k], first + k * 1024); end
            end
            total++; if (done_n != 1) begin bad++; $display("FAIL rnd%0d_done_cnt: got %0d want 1", r, done_n); end
            total++; if (done_cyc != last) begin bad++; $display("FAIL rnd%0d_done_time: got %0d want %0d", r, done_cyc, last); end
            cur[2] = t;
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_equal();
        test_reset_mid();
        test_retarget();
        test_full_swing();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
